// File: rtl/mem_master_pkg.sv
// mem_master_pkg: shared definitions for the mem_master block.
//   - state_t: FSM encoding (IDLE, REQ, REL, RSP)
//   - DEF_WORD_SIZE / DEF_ADDR_SIZE / DEF_TIMEOUT_CYCLES: parameter defaults
package mem_master_pkg;

    localparam int DEF_WORD_SIZE      = 32;
    localparam int DEF_ADDR_SIZE      = 64;
    localparam int DEF_TIMEOUT_CYCLES = 255;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,  // waiting for a client request
        ST_REQ  = 2'd1,  // mem_txs=1, waiting for mem_txe=1
        ST_REL  = 2'd2,  // mem_txs=0, waiting for mem_txe=0
        ST_RSP  = 2'd3   // rsp_valid=1, waiting for rsp_ready
    } state_t;

endpackage

// File: rtl/mem_master_watchdog.sv
// mem_master_watchdog: cycle counter that bounds how long the master waits on
// one phase of the memory handshake.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   clear     - zero the count (wins over enable)
//   enable    - count one cycle
//   expired   - high in the LIMIT-th enabled cycle since the last clear
module mem_master_watchdog #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    // The count reads k-1 during the k-th enabled cycle, so the phase lasts
    // exactly LIMIT cycles before it is forced to end.
    assign expired = enable && (count == CW'(LIMIT - 1));

endmodule

// File: rtl/mem_master.sv
// mem_master: client request/response front end that drives a memory
// responder through a four-phase handshake (mem_txs up, mem_txe up,
// mem_txs down, mem_txe down).
// Configuration macro: MEM_MASTER_TIMEOUT_EN adds a watchdog that ends a
// stalled REQ or REL phase after TIMEOUT_CYCLES cycles with an error.
// Ports:
//   clk, rst                      - clock, asynchronous active-high reset
//   req_valid/req_ready           - client request handshake
//   req_write, req_addr, req_wdata- request command
//   rsp_valid/rsp_ready           - client response handshake
//   rsp_rdata, rsp_err, rsp_timeout - response payload
//   mem_read, mem_write, mem_addr, mem_value - command to the responder
//   mem_txs (out) / mem_txe (in)  - four-phase handshake lines
//   mem_out, mem_err              - responder data and error
//   dbg_state                     - current FSM state
//
// Handshake semantics: a request transfers on a rising edge where
// req_valid && req_ready; a response transfers on a rising edge where
// rsp_valid && rsp_ready. Once raised, rsp_valid and its payload hold
// steady until the transfer; req_valid is never required to wait on
// req_ready and req_ready never depends on req_valid.
module mem_master
    import mem_master_pkg::*;
#(
    parameter int WORD_SIZE      = DEF_WORD_SIZE,
    parameter int ADDR_SIZE      = DEF_ADDR_SIZE,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [ADDR_SIZE-1:0] req_addr,
    input  logic [WORD_SIZE-1:0] req_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [WORD_SIZE-1:0] rsp_rdata,
    output logic                 rsp_err,
    output logic                 rsp_timeout,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_value,
    output logic                 mem_txs,
    input  logic                 mem_txe,
    input  logic [WORD_SIZE-1:0] mem_out,
    input  logic                 mem_err,
    output state_t               dbg_state
);

    state_t state;
    logic   wd_expired;

`ifdef MEM_MASTER_TIMEOUT_EN
    logic wd_clear;
    logic wd_enable;

    // Held clear in IDLE and on the REQ->REL step so each phase starts at 0.
    assign wd_clear  = (state == ST_IDLE) ||
                       ((state == ST_REQ) && (mem_txe || wd_expired));
    assign wd_enable = (state == ST_REQ) || (state == ST_REL);

    mem_master_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );
`else
    // Without the watchdog the handshake phases wait forever; the timeout
    // limit is meaningless in this build.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign wd_expired         = 1'b0;
`endif

    // A responder still holding mem_txe high (e.g. after a reset that
    // abandoned a transaction) must release it before a new mem_txs.
    assign req_ready = (state == ST_IDLE) && !mem_txe;
    assign dbg_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            mem_txs     <= 1'b0;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_addr    <= '0;
            mem_value   <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        mem_read    <= ~req_write;
                        mem_write   <= req_write;
                        mem_addr    <= req_addr;
                        mem_value   <= req_wdata;
                        mem_txs     <= 1'b1;
                        rsp_rdata   <= '0;
                        rsp_err     <= 1'b0;
                        rsp_timeout <= 1'b0;
                        state       <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (mem_txe) begin
                        // Writes return no data.
                        rsp_rdata <= mem_read ? mem_out : '0;
                        rsp_err   <= mem_err;
                        mem_txs   <= 1'b0;
                        state     <= ST_REL;
                    end else if (wd_expired) begin
                        rsp_rdata   <= '0;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        mem_txs     <= 1'b0;
                        state       <= ST_REL;
                    end
                end
                ST_REL: begin
                    if (!mem_txe || wd_expired) begin
                        if (mem_txe) begin
                            rsp_err     <= 1'b1;
                            rsp_timeout <= 1'b1;
                        end
                        mem_read  <= 1'b0;
                        mem_write <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= ST_RSP;
                    end
                end
                ST_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_master.sv
// tb_mem_master: directed bench for mem_master with a combinational memory
// responder (acknowledges each handshake edge within the same cycle), a
// response scoreboard fed by the stimulus and drained by a monitor, and
// directed timing checks.
module tb_mem_master;
    import mem_master_pkg::*;

    localparam int W    = 32;
    localparam int A    = 64;
    localparam int TO   = 8;
    localparam int SIZE = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         req_valid = 1'b0;
    logic         req_ready;
    logic         req_write = 1'b0;
    logic [A-1:0] req_addr  = '0;
    logic [W-1:0] req_wdata = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [W-1:0] rsp_rdata;
    logic         rsp_err;
    logic         rsp_timeout;
    logic         mem_read;
    logic         mem_write;
    logic [A-1:0] mem_addr;
    logic [W-1:0] mem_value;
    logic         mem_txs;
    logic         mem_txe;
    logic [W-1:0] mem_out;
    logic         mem_err;
    state_t       dbg_state;

    mem_master #(
        .WORD_SIZE      (W),
        .ADDR_SIZE      (A),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_addr    (mem_addr),
        .mem_value   (mem_value),
        .mem_txs     (mem_txs),
        .mem_txe     (mem_txe),
        .mem_out     (mem_out),
        .mem_err     (mem_err),
        .dbg_state   (dbg_state)
    );

    // ---------------- memory responder model ----------------
    logic [W-1:0] mem_arr [SIZE];
    logic         force_txe = 1'b0;  // hold mem_txe high regardless of mem_txs
    logic         silent    = 1'b0;  // never acknowledge
    logic         in_range;

    assign in_range = (mem_addr < A'(SIZE));
    assign mem_txe  = force_txe | (mem_txs & ~silent);
    assign mem_out  = (mem_read && in_range) ? mem_arr[mem_addr[3:0]] : '0;
    assign mem_err  = mem_txs & ~in_range & ~silent;

    always @(posedge clk) begin
        if (mem_txs && mem_write && !silent && in_range)
            mem_arr[mem_addr[3:0]] <= mem_value;
    end

    // ---------------- scoreboard ----------------
    int n_pass  = 0;
    int n_total = 0;
    logic [W+1:0] exp_q[$];  // {timeout, err, rdata}
    logic [W+1:0] mon_e;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic expect_rsp(input logic to, input logic err, input logic [W-1:0] rdata);
        exp_q.push_back({to, err, rdata});
    endtask

    // Monitor: compares every accepted response against the next expectation.
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_rsp: got rdata 0x%0h, expected no response", rsp_rdata);
            end else begin
                mon_e = exp_q.pop_front();
                check("rsp_rdata",   64'(rsp_rdata),   64'(mon_e[W-1:0]));
                check("rsp_err",     64'(rsp_err),     64'(mon_e[W]));
                check("rsp_timeout", 64'(rsp_timeout), 64'(mon_e[W+1]));
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Present a request until accepted; returns at accept edge + 1.
    task automatic issue(input logic wr, input logic [A-1:0] addr, input logic [W-1:0] wd);
        bit ok;
        ok = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wd;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("req_accepted", 64'(ok), 64'd1);
    endtask

    // Cycles from acceptance until rsp_valid, and cycles mem_txs was high.
    task automatic wait_rsp(output int lat, output int txs_hi);
        lat    = 0;
        txs_hi = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (mem_txs) txs_hi++;
            if (rsp_valid) begin
                lat = i;
                break;
            end
        end
        if (lat == 0) check("rsp_valid_within_bound", 64'(rsp_valid), 64'd1);
    endtask

    // Hold off rsp_ready for `hold` cycles (with a competing request
    // present), checking the response stays put, then accept it.
    task automatic finish_rsp(input int hold);
        logic [W-1:0] d0;
        d0 = rsp_rdata;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            req_valid = 1'b1;
            req_write = 1'b1;
            req_addr  = A'(1);
            @(negedge clk);
            check("hold_rsp_valid", 64'(rsp_valid), 64'd1);
            check("hold_rsp_rdata", 64'(rsp_rdata), 64'(d0));
            check("hold_req_ready", 64'(req_ready), 64'd0);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic txn(input logic wr, input logic [A-1:0] addr, input logic [W-1:0] wd,
                       input logic err, input logic [W-1:0] rdata, input int hold);
        int lat;
        int txs_hi;
        expect_rsp(1'b0, err, rdata);
        issue(wr, addr, wd);
        wait_rsp(lat, txs_hi);
        check("latency", 64'(lat), 64'd3);
        check("txs_cycles", 64'(txs_hi), 64'd1);
        finish_rsp(hold);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int cnt;
        for (int i = 0; i < SIZE; i++) mem_arr[i] = 32'hA000 + 32'(i);
        mem_arr[5] = 32'd42;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mem_txs",   64'(mem_txs),   64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_state",     64'(dbg_state), 64'(ST_IDLE));
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_req_ready",   64'(req_ready),   64'd1);
        check("rst_mem_read",    64'(mem_read),    64'd0);
        check("rst_mem_write",   64'(mem_write),   64'd0);
        check("rst_mem_addr",    64'(mem_addr),    64'd0);
        check("rst_mem_value",   64'(mem_value),   64'd0);
        check("rst_rsp_rdata",   64'(rsp_rdata),   64'd0);
        check("rst_rsp_err",     64'(rsp_err),     64'd0);
        check("rst_rsp_timeout", 64'(rsp_timeout), 64'd0);

        // Read [5]=42, write then read back, out-of-range read, held response
        txn(1'b0, A'(5),  '0,          1'b0, 32'd42,     0);
        txn(1'b1, A'(7),  32'h1234,    1'b0, 32'd0,      0);
        txn(1'b0, A'(7),  '0,          1'b0, 32'h1234,   0);
        txn(1'b0, A'(20), '0,          1'b1, 32'd0,      0);
        txn(1'b0, A'(9),  '0,          1'b0, 32'hA009,   10);

        // Reset while in REQ with the responder holding mem_txe high
        issue(1'b0, A'(3), '0);
        @(negedge clk);
        check("abort_in_req", 64'(dbg_state), 64'(ST_REQ));
        force_txe = 1'b1;
        rst       = 1'b1;
        #1;
        check("abort_txs_async", 64'(mem_txs),   64'd0);
        check("abort_state",     64'(dbg_state), 64'(ST_IDLE));
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("abort_req_ready", 64'(req_ready), 64'd0);
            check("abort_rsp_valid", 64'(rsp_valid), 64'd0);
            check("abort_mem_txs",   64'(mem_txs),   64'd0);
        end
        @(posedge clk); #1;
        force_txe = 1'b0;
        @(negedge clk);
        check("release_req_ready", 64'(req_ready), 64'd1);

`ifdef MEM_MASTER_TIMEOUT_EN
        // Silent responder: watchdog ends REQ after TO cycles
        silent = 1'b1;
        expect_rsp(1'b1, 1'b1, 32'd0);
        issue(1'b0, A'(2), '0);
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (mem_txs) cnt++;
            else if (cnt > 0) break;
        end
        check("timeout_txs_cycles", 64'(cnt), 64'(TO));
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (rsp_valid) break;
            @(negedge clk);
            cnt++;
        end
        check("timeout_rsp_valid", 64'(rsp_valid), 64'd1);
        finish_rsp(0);
        silent = 1'b0;
`else
        cnt = 0;
`endif

        // Normal operation after the abort (and timeout, when built in)
        txn(1'b0, A'(5), '0, 1'b0, 32'd42, 0);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
